// File: rtl/stream_xbar_arbiter.sv
// ----------------------------------------------------------------------------
// stream_xbar_arbiter
//    Per-output packet arbiter for the stream crossbar. Each input stream's
//    destination is decoded, and every output independently arbitrates
//    round-robin among the inputs that want it. A grant is held until the
//    packet's last beat has been accepted.
//
//    Ports
//       clk_i      clock, all state on the rising edge
//       rst_i      asynchronous reset, active-high
//       s_dest_i   destination output index, one field per input
//       s_valid_i  beat valid per input
//       s_last_i   last beat of packet per input
//       s_ready_o  ready back to each input (granted output's m_ready_i)
//       m_ready_i  ready from each output sink
//       req_o      req_o[j] = one-hot grant of inputs to output j (0 = idle)
// ----------------------------------------------------------------------------

// Per-output arbiter lane: IDLE/BUSY FSM, grant register, round-robin pointer.
//    req_i      inputs requesting this output (already excludes granted ones)
//    valid_i    raw input valid, used for the handshake of the granted input
//    last_i     raw input last
//    m_ready_i  this output's sink ready
//    grant_o    registered one-hot grant (zero while IDLE)
module stream_xbar_arbiter_out #(
   parameter int S_DATA_COUNT = 2,
   parameter int PTR_W        = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [S_DATA_COUNT-1:0] req_i,
   input  logic [S_DATA_COUNT-1:0] valid_i,
   input  logic [S_DATA_COUNT-1:0] last_i,
   input  logic                    m_ready_i,
   output logic [S_DATA_COUNT-1:0] grant_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state_q, state_d;
   logic [S_DATA_COUNT-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic                    found;
   logic [PTR_W-1:0]        win;
   logic                    last_hs;

   // Round-robin search starting just after the last winner.
   always_comb begin
      logic [PTR_W-1:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= S_DATA_COUNT; k++) begin
         idx = PTR_W'((int'(ptr_q) + k) % S_DATA_COUNT);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Only the granted input's bits survive the mask, so this is the
   // handshake of the packet owner on its last beat.
   assign last_hs = (|(grant_q & valid_i & last_i)) & m_ready_i;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = S_DATA_COUNT'(1) << win;
               ptr_d   = win;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Valid gaps and destination changes keep the lock; only an
            // accepted last beat releases it.
            if (last_hs) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Pointer resets to the highest index so input 0 has first priority.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PTR_W'(S_DATA_COUNT - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o = grant_q;

endmodule

module stream_xbar_arbiter #(
   parameter  int S_DATA_COUNT = 2,
   parameter  int M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
   input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
   input  logic [S_DATA_COUNT-1:0]                   s_last_i,
   output logic [S_DATA_COUNT-1:0]                   s_ready_o,
   input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
   output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_o
);

   localparam int PTR_W = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant;
   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_vec;
   logic [S_DATA_COUNT-1:0]                   busy;

   // An input already owned by some output may not request again; with one
   // destination per input this keeps every input on at most one output.
   always_comb begin
      busy = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) busy = busy | grant[j];
   end

   // Destinations >= M_DATA_COUNT match no output and are never granted.
   always_comb begin
      req_vec = '0;
      for (int j = 0; j < M_DATA_COUNT; j++)
         for (int i = 0; i < S_DATA_COUNT; i++)
            req_vec[j][i] = s_valid_i[i] && !busy[i] &&
                            (s_dest_i[i] == T_DEST_WIDTH'(j));
   end

   for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
      stream_xbar_arbiter_out #(
         .S_DATA_COUNT(S_DATA_COUNT),
         .PTR_W       (PTR_W)
      ) u_out (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .req_i    (req_vec[j]),
         .valid_i  (s_valid_i),
         .last_i   (s_last_i),
         .m_ready_i(m_ready_i[j]),
         .grant_o  (grant[j])
      );
   end

   // Ready comes only from registered grants and sink ready, never from valid.
   always_comb begin
      s_ready_o = '0;
      for (int j = 0; j < M_DATA_COUNT; j++)
         s_ready_o = s_ready_o | (grant[j] & {S_DATA_COUNT{m_ready_i[j]}});
   end

   assign req_o = grant;

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
module tb_stream_xbar_arbiter;

   localparam int S = 2;
   localparam int M = 3;
   localparam int TW = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [S-1:0][TW-1:0]  s_dest_i;
   logic [S-1:0]          s_valid_i;
   logic [S-1:0]          s_last_i;
   logic [S-1:0]          s_ready_o;
   logic [M-1:0]          m_ready_i;
   logic [M-1:0][S-1:0]   req_o;

   int n_chk  = 0;
   int n_pass = 0;

   stream_xbar_arbiter #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .s_dest_i (s_dest_i),
      .s_valid_i(s_valid_i),
      .s_last_i (s_last_i),
      .s_ready_o(s_ready_o),
      .m_ready_i(m_ready_i),
      .req_o    (req_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_in();
      s_valid_i = '0;
      s_last_i  = '0;
   endtask

   task automatic do_reset();
      idle_in();
      #2 rst_i = 1'b1;
      tick();
      tick();
      #2 rst_i = 1'b0;
      tick();
   endtask

   initial begin
      rst_i     = 1'b1;
      s_dest_i  = '0;
      s_valid_i = '0;
      s_last_i  = '0;
      m_ready_i = 3'b111;
      tick();
      settle();
      // 1. reset state
      chk("rst_req0", 8'(req_o[0]), 8'h0);
      chk("rst_req1", 8'(req_o[1]), 8'h0);
      chk("rst_req2", 8'(req_o[2]), 8'h0);
      chk("rst_rdy",  8'(s_ready_o), 8'h0);
      #2 rst_i = 1'b0;
      tick();

      // 2. single 3-beat packet, input0 -> output 2
      s_dest_i[0] = 2'd2; s_valid_i = 2'b01; s_last_i = 2'b00;
      settle();
      chk("p_c0_req2", 8'(req_o[2]), 8'h0);
      tick(); settle();
      chk("p_c1_req2", 8'(req_o[2]), 8'h1);
      chk("p_c1_rdy",  8'(s_ready_o), 8'h1);
      tick(); settle();
      chk("p_c2_rdy",  8'(s_ready_o), 8'h1);
      tick(); s_last_i = 2'b01; settle();
      chk("p_c3_req2", 8'(req_o[2]), 8'h1);
      chk("p_c3_rdy",  8'(s_ready_o), 8'h1);
      tick(); idle_in(); settle();
      chk("p_c4_req2", 8'(req_o[2]), 8'h0);
      chk("p_c4_rdy",  8'(s_ready_o), 8'h0);

      // 3. contention on output 1, round-robin alternation
      do_reset();
      s_dest_i[0] = 2'd1; s_dest_i[1] = 2'd1; s_valid_i = 2'b11; s_last_i = 2'b00;
      tick(); settle();
      chk("c_c1_req1", 8'(req_o[1]), 8'h1);
      chk("c_c1_rdy",  8'(s_ready_o), 8'h1);
      tick(); s_last_i = 2'b01; settle();
      chk("c_c2_req1", 8'(req_o[1]), 8'h1);
      tick(); s_valid_i = 2'b10; s_last_i = 2'b00; settle();
      chk("c_c3_bubble", 8'(req_o[1]), 8'h0);
      tick(); settle();
      chk("c_c4_req1", 8'(req_o[1]), 8'h2);
      chk("c_c4_rdy",  8'(s_ready_o), 8'h2);
      tick(); s_valid_i = 2'b11; s_last_i = 2'b10; settle();
      chk("c_c5_req1", 8'(req_o[1]), 8'h2);
      tick(); s_valid_i = 2'b01; s_last_i = 2'b00; settle();
      chk("c_c6_bubble", 8'(req_o[1]), 8'h0);
      tick(); settle();
      chk("c_c7_req1", 8'(req_o[1]), 8'h1);
      s_last_i = 2'b01;
      tick(); idle_in(); settle();
      chk("c_c8_req1", 8'(req_o[1]), 8'h0);

      // 4. parallel grants on different outputs, single-beat packets
      do_reset();
      s_dest_i[0] = 2'd0; s_dest_i[1] = 2'd2; s_valid_i = 2'b11; s_last_i = 2'b11;
      tick(); settle();
      chk("par_req0", 8'(req_o[0]), 8'h1);
      chk("par_req2", 8'(req_o[2]), 8'h2);
      chk("par_rdy",  8'(s_ready_o), 8'h3);
      tick(); idle_in(); settle();
      chk("par_rel0", 8'(req_o[0]), 8'h0);
      chk("par_rel2", 8'(req_o[2]), 8'h0);

      // 5. backpressure and valid gap
      do_reset();
      s_dest_i[0] = 2'd2; s_valid_i = 2'b01; s_last_i = 2'b00;
      tick(); m_ready_i = 3'b011; s_last_i = 2'b01; settle();
      chk("bp_req2", 8'(req_o[2]), 8'h1);
      chk("bp_rdy",  8'(s_ready_o), 8'h0);
      tick(); s_valid_i = 2'b00; settle();
      chk("bp_hold", 8'(req_o[2]), 8'h1);
      tick(); settle();
      chk("gap_hold", 8'(req_o[2]), 8'h1);
      chk("gap_rdy",  8'(s_ready_o), 8'h0);
      m_ready_i = 3'b111; s_valid_i = 2'b01; s_last_i = 2'b01; settle();
      chk("bp_rdy_up", 8'(s_ready_o), 8'h1);
      tick(); idle_in(); settle();
      chk("bp_rel", 8'(req_o[2]), 8'h0);

      // 6a. invalid destination is never granted
      s_dest_i[1] = 2'd3; s_valid_i = 2'b10; s_last_i = 2'b00;
      for (int c = 0; c < 5; c++) begin
         tick(); settle();
         chk("inv_rdy", 8'(s_ready_o), 8'h0);
         chk("inv_req", 8'(req_o), 8'h0);
      end
      idle_in();

      // 6b. async reset mid-packet, then pointer back to input-0 priority
      tick();
      s_dest_i[0] = 2'd1; s_valid_i = 2'b01;
      tick(); settle();
      chk("mr_req1", 8'(req_o[1]), 8'h1);
      #2 rst_i = 1'b1;
      #1;
      chk("mr_async_req", 8'(req_o), 8'h0);
      chk("mr_async_rdy", 8'(s_ready_o), 8'h0);
      tick();
      #2 rst_i = 1'b0;
      s_dest_i[0] = 2'd1; s_dest_i[1] = 2'd1; s_valid_i = 2'b11;
      tick(); settle();
      chk("mr_rr_req1", 8'(req_o[1]), 8'h1);
      idle_in();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
